ram_bus_master: RTL and testbench



---
 rtl/ram_bus_master.sv | 141 ++++++++++++++
 tb/tb_ram_bus_master.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bus_master.sv
// ram_bus_master: burst initiator for a single-port synchronous RAM on a shared
// address / bidirectional data / write-strobe bus. Accepts read or write burst
// commands, streams write words in and read words out, and drives the data bus
// only while its write strobe is high.
module ram_bus_master #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_w,
    inout  wire  [DATA_W-1:0] mem_data
);

    // Handshakes (cmd, wr, rd): a transfer happens on a rising edge where both
    // valid and ready are high. A source keeps valid and its payload stable
    // until that edge; ready never depends combinationally on valid.

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR       = 2'd1,
        RD       = 2'd2,
        RD_DRAIN = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                cmd_fire;
    logic                wr_fire;
    logic                rd_capture;
    logic [ADDR_W-1:0]   addr_cnt;
    logic [2:0]          word_cnt;
    logic [DATA_W-1:0]   dout;

    // The bus is owned by whoever mem_w selects, so the RAM and this block can
    // never drive it in the same cycle.
    assign mem_data = mem_w ? dout : {DATA_W{1'bz}};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_d    = state_q;
        cmd_ready  = 1'b0;
        wr_ready   = 1'b0;
        busy       = 1'b1;
        cmd_fire   = 1'b0;
        wr_fire    = 1'b0;
        rd_capture = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                cmd_fire  = cmd_valid;
                if (cmd_valid) begin
                    state_d = cmd_write ? WR : RD;
                end
            end
            WR: begin
                wr_ready = 1'b1;
                wr_fire  = wr_valid;
                if (wr_valid && (word_cnt == 3'd0)) begin
                    state_d = IDLE;
                end
            end
            RD: begin
                // A new word may be captured whenever the output slot is empty
                // or is being handed off on this edge.
                rd_capture = !rd_valid || rd_ready;
                if (rd_capture && (word_cnt == 3'd0)) begin
                    state_d = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                if (rd_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: address/word counters, RAM bus registers and read output slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_w    <= 1'b0;
            mem_addr <= '0;
            addr_cnt <= '0;
            word_cnt <= '0;
            dout     <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            // Strobe is high only for the cycle following an accepted word,
            // so a stalled write stream never repeats a write.
            mem_w <= wr_fire;
            if (cmd_fire) begin
                addr_cnt <= cmd_addr;
                word_cnt <= cmd_len;
                if (!cmd_write) begin
                    mem_addr <= cmd_addr;
                end
            end
            if (wr_fire) begin
                mem_addr <= addr_cnt;
                dout     <= wr_data;
                addr_cnt <= addr_cnt + 1'b1;
                word_cnt <= word_cnt - 1'b1;
            end
            if (rd_capture) begin
                rd_data  <= mem_data;
                rd_valid <= 1'b1;
                mem_addr <= mem_addr + 1'b1;
                word_cnt <= word_cnt - 1'b1;
            end else if (rd_ready) begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ram_bus_master.sv
// Bench for ram_bus_master: a behavioural single-port RAM on the shared bus,
// directed scenarios with hand-computed expectations, and a final summary.
module tb_ram_bus_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [5:0]  cmd_addr;
    logic [2:0]  cmd_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [11:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [11:0] rd_data;
    logic        busy;
    logic [5:0]  mem_addr;
    logic        mem_w;
    wire  [11:0] mem_data;

    int checks = 0;
    int errors = 0;

    logic [11:0] ram [64];

    ram_bus_master #(.ADDR_W(6), .DATA_W(12)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .mem_addr(mem_addr), .mem_w(mem_w), .mem_data(mem_data)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: stores on the rising edge, drives the bus only while not written.
    always @(posedge clk) begin
        if (mem_w) ram[mem_addr] <= mem_data;
    end
    assign mem_data = mem_w ? 12'bz : ram[mem_addr];

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic wr, input logic [5:0] a, input logic [2:0] len);
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_ready_timeout got %0d want 1", cmd_ready); end
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_len   = len;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic send_word(input logic [11:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic recv_words(input int n, output logic [11:0] got [8], output int cnt);
        int guard;
        cnt   = 0;
        guard = 0;
        for (int i = 0; i < 8; i++) got[i] = '0;
        while (cnt < n && guard < 60) begin
            if (rd_valid) begin
                got[cnt] = rd_data;
                cnt++;
                rd_ready = 1'b1;
            end else begin
                rd_ready = 1'b0;
            end
            tick();
            guard++;
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %0d want 1", cmd_ready); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready got %0d want 0", wr_ready); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %0d want 0", rd_valid); end
        checks++; if (rd_data !== 12'd0) begin errors++; $display("FAIL reset_rd_data got %0d want 0", rd_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0d want 0", busy); end
        checks++; if (mem_w !== 1'b0) begin errors++; $display("FAIL reset_mem_w got %0d want 0", mem_w); end
        checks++; if (mem_addr !== 6'd0) begin errors++; $display("FAIL reset_mem_addr got %0d want 0", mem_addr); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [11:0] got [8];
        int cnt;
        send_cmd(1'b1, 6'd2, 3'd0);
        checks++; if (busy !== 1'b1 || wr_ready !== 1'b1) begin errors++; $display("FAIL single_wr_state busy %0d wr_ready %0d want 1 1", busy, wr_ready); end
        checks++; if (mem_w !== 1'b0) begin errors++; $display("FAIL single_mem_w_pre got %0d want 0", mem_w); end
        send_word(12'd10);
        checks++; if (mem_w !== 1'b1 || mem_addr !== 6'd2 || mem_data !== 12'd10) begin errors++; $display("FAIL single_bus_write mem_w %0d addr %0d data %0d want 1 2 10", mem_w, mem_addr, mem_data); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL single_wr_done got %0d want 1", cmd_ready); end
        tick();
        checks++; if (mem_w !== 1'b0) begin errors++; $display("FAIL single_mem_w_post got %0d want 0", mem_w); end
        checks++; if (ram[2] !== 12'd10) begin errors++; $display("FAIL single_ram2 got %0d want 10", ram[2]); end
        send_cmd(1'b0, 6'd2, 3'd0);
        checks++; if (rd_valid !== 1'b0 || mem_addr !== 6'd2) begin errors++; $display("FAIL single_rd_edge0 rd_valid %0d addr %0d want 0 2", rd_valid, mem_addr); end
        tick();
        checks++; if (rd_valid !== 1'b1 || rd_data !== 12'd10) begin errors++; $display("FAIL single_rd_edge1 rd_valid %0d data %0d want 1 10", rd_valid, rd_data); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_rd_busy got %0d want 1", busy); end
        recv_words(1, got, cnt);
        checks++; if (cnt !== 1 || got[0] !== 12'd10) begin errors++; $display("FAIL single_rd_data cnt %0d data %0d want 1 10", cnt, got[0]); end
        checks++; if (rd_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL single_rd_done rd_valid %0d cmd_ready %0d want 0 1", rd_valid, cmd_ready); end
    endtask

    task automatic test_burst_wrap();
        logic [11:0] got [8];
        int cnt;
        logic [5:0] a;
        send_cmd(1'b1, 6'd62, 3'd3);
        send_word(12'd1);
        send_word(12'd2);
        send_word(12'd3);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wrap_busy_mid got %0d want 1", busy); end
        send_word(12'd4);
        checks++; if (cmd_ready !== 1'b1 || mem_addr !== 6'd1) begin errors++; $display("FAIL wrap_wr_done cmd_ready %0d addr %0d want 1 1", cmd_ready, mem_addr); end
        tick();
        for (int i = 0; i < 4; i++) begin
            a = 6'd62 + 6'(i);
            checks++; if (ram[a] !== 12'(i + 1)) begin errors++; $display("FAIL wrap_ram addr %0d got %0d want %0d", a, ram[a], i + 1); end
        end
        send_cmd(1'b0, 6'd62, 3'd3);
        recv_words(4, got, cnt);
        checks++; if (cnt !== 4) begin errors++; $display("FAIL wrap_rd_count got %0d want 4", cnt); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (got[i] !== 12'(i + 1)) begin errors++; $display("FAIL wrap_rd_word %0d got %0d want %0d", i, got[i], i + 1); end
        end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wrap_rd_done got %0d want 1", cmd_ready); end
    endtask

    task automatic test_read_stall();
        logic [11:0] got [8];
        int cnt;
        send_cmd(1'b0, 6'd62, 3'd3);
        rd_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (rd_valid !== 1'b1 || rd_data !== 12'd1) begin errors++; $display("FAIL stall_hold cycle %0d rd_valid %0d data %0d want 1 1", i, rd_valid, rd_data); end
        end
        recv_words(4, got, cnt);
        checks++; if (cnt !== 4) begin errors++; $display("FAIL stall_count got %0d want 4", cnt); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (got[i] !== 12'(i + 1)) begin errors++; $display("FAIL stall_word %0d got %0d want %0d", i, got[i], i + 1); end
        end
    endtask

    task automatic test_write_gaps();
        send_cmd(1'b1, 6'd20, 3'd1);
        send_word(12'h111);
        checks++; if (mem_w !== 1'b1 || mem_addr !== 6'd20) begin errors++; $display("FAIL gap_w0 mem_w %0d addr %0d want 1 20", mem_w, mem_addr); end
        tick();
        checks++; if (mem_w !== 1'b0) begin errors++; $display("FAIL gap_idle1 mem_w %0d want 0", mem_w); end
        tick();
        checks++; if (mem_w !== 1'b0 || wr_ready !== 1'b1) begin errors++; $display("FAIL gap_idle2 mem_w %0d wr_ready %0d want 0 1", mem_w, wr_ready); end
        send_word(12'h222);
        checks++; if (mem_w !== 1'b1 || mem_addr !== 6'd21 || mem_data !== 12'h222) begin errors++; $display("FAIL gap_w1 mem_w %0d addr %0d data %0h want 1 21 222", mem_w, mem_addr, mem_data); end
        tick();
        checks++; if (mem_w !== 1'b0) begin errors++; $display("FAIL gap_end mem_w %0d want 0", mem_w); end
        checks++; if (ram[20] !== 12'h111 || ram[21] !== 12'h222) begin errors++; $display("FAIL gap_ram got %0h %0h want 111 222", ram[20], ram[21]); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] got [8];
        int cnt;
        send_cmd(1'b1, 6'd3, 3'd0);
        send_word(12'd20);
        checks++; if (mem_w !== 1'b1 || mem_data !== 12'd20) begin errors++; $display("FAIL b2b_write mem_w %0d data %0d want 1 20", mem_w, mem_data); end
        send_cmd(1'b0, 6'd3, 3'd0);
        checks++; if (ram[3] !== 12'd20) begin errors++; $display("FAIL b2b_ram3 got %0d want 20", ram[3]); end
        checks++; if (mem_w !== 1'b0 || mem_addr !== 6'd3 || mem_data !== 12'd20) begin errors++; $display("FAIL b2b_turn mem_w %0d addr %0d data %0d want 0 3 20", mem_w, mem_addr, mem_data); end
        recv_words(1, got, cnt);
        checks++; if (cnt !== 1 || got[0] !== 12'd20) begin errors++; $display("FAIL b2b_read cnt %0d data %0d want 1 20", cnt, got[0]); end
    endtask

    task automatic test_reset_mid_write();
        logic [11:0] got [8];
        int cnt;
        send_cmd(1'b1, 6'd42, 3'd1);
        send_word(12'h5a5);
        send_word(12'h0a5);
        send_cmd(1'b1, 6'd40, 3'd3);
        send_word(12'd100);
        send_word(12'd101);
        send_word(12'd102);
        checks++; if (mem_w !== 1'b1 || mem_addr !== 6'd42) begin errors++; $display("FAIL rstmid_pre mem_w %0d addr %0d want 1 42", mem_w, mem_addr); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (mem_w !== 1'b0) begin errors++; $display("FAIL rstmid_mem_w got %0d want 0", mem_w); end
        checks++; if (mem_data !== 12'd3) begin errors++; $display("FAIL rstmid_bus_released got %0d want 3", mem_data); end
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || mem_addr !== 6'd0) begin errors++; $display("FAIL rstmid_state busy %0d cmd_ready %0d addr %0d want 0 1 0", busy, cmd_ready, mem_addr); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (cmd_ready !== 1'b1 || wr_ready !== 1'b0) begin errors++; $display("FAIL rstmid_after cmd_ready %0d wr_ready %0d want 1 0", cmd_ready, wr_ready); end
        checks++; if (ram[40] !== 12'd100 || ram[41] !== 12'd101) begin errors++; $display("FAIL rstmid_kept got %0d %0d want 100 101", ram[40], ram[41]); end
        checks++; if (ram[42] !== 12'h5a5 || ram[43] !== 12'h0a5) begin errors++; $display("FAIL rstmid_untouched got %0h %0h want 5a5 0a5", ram[42], ram[43]); end
        send_cmd(1'b0, 6'd40, 3'd1);
        recv_words(2, got, cnt);
        checks++; if (cnt !== 2 || got[0] !== 12'd100 || got[1] !== 12'd101) begin errors++; $display("FAIL rstmid_readback cnt %0d data %0d %0d want 2 100 101", cnt, got[0], got[1]); end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;
        test_reset();
        test_single();
        test_burst_wrap();
        test_read_stall();
        test_write_gaps();
        test_back_to_back();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
